// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receive-side model of an HD44780-style character LCD bus.
// Define LCD_DECODE_4BIT_EN for 4-bit nibble assembly and DL tracking.
module lcd_bus_decoder #(
    parameter int CLEAR_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_db,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic       char_valid,
    output logic [7:0] rx_byte,
    output logic [6:0] cursor,
    output logic       four_bit,
    output logic       display_on,
    output logic       busy,
    output logic       proto_err
);

    localparam logic [1:0] IDLE    = 2'd0;
`ifdef LCD_DECODE_4BIT_EN
    localparam logic [1:0] LOW_NIB = 2'd1;
`endif
    localparam logic [1:0] CLEAR   = 2'd2;
    localparam logic [4:0] CLR_LAST = 5'(CLEAR_CYCLES - 1);

    logic       e_q, rs_q, rw_q;
    logic [7:0] db_q;
    logic [1:0] state;
    logic [4:0] clr_idx;
    logic       inc;
    logic [7:0] mem [0:31];

    logic       fall, in_clear, acc, bad, rs_err;
    logic       exec, exec_rs;
    logic [7:0] exec_byte;
    logic [6:0] cur_n;
    logic       inc_n, disp_n, go_clr;
    logic [4:0] wr_addr;

`ifdef LCD_DECODE_4BIT_EN
    logic [3:0] hi_nib;
    logic       hi_rs, dl, dl_n, hi_edge, lo_edge;
    assign four_bit = dl;
`else
    assign four_bit = 1'b0;
`endif

    // Step the DDRAM address within the two 16-column lines
    function automatic logic [6:0] adv(input logic [6:0] c, input logic up);
        logic [6:0] r;
        if (up) begin
            if (c == 7'h0F)      r = 7'h40;
            else if (c == 7'h4F) r = 7'h00;
            else                 r = c + 7'd1;
        end else begin
            if (c == 7'h00)      r = 7'h4F;
            else if (c == 7'h40) r = 7'h0F;
            else                 r = c - 7'd1;
        end
        return r;
    endfunction

    assign fall     = e_q & ~lcd_e;
    assign in_clear = (state == CLEAR);
    assign busy     = in_clear;
    assign acc      = fall & ~in_clear & ~rw_q;
    assign bad      = fall & (in_clear | rw_q);
    assign wr_addr  = {cursor[6], cursor[3:0]};

    // Byte assembly: full-byte edges or a high/low nibble pair
    always_comb begin
`ifdef LCD_DECODE_4BIT_EN
        hi_edge   = acc & (state == IDLE) & dl;
        lo_edge   = acc & (state == LOW_NIB);
        exec      = (acc & (state == IDLE) & ~dl) | lo_edge;
        exec_byte = lo_edge ? {hi_nib, db_q[7:4]} : db_q;
        exec_rs   = lo_edge ? hi_rs : rs_q;
        rs_err    = lo_edge & (rs_q != hi_rs);
`else
        exec      = acc;
        exec_byte = db_q;
        exec_rs   = rs_q;
        rs_err    = 1'b0;
`endif
    end

    // Command decode and cursor update for an executed byte
    always_comb begin
        cur_n  = cursor;
        inc_n  = inc;
        disp_n = display_on;
        go_clr = 1'b0;
`ifdef LCD_DECODE_4BIT_EN
        dl_n   = dl;
`endif
        if (exec) begin
            if (exec_rs) begin
                cur_n = adv(cursor, inc);
            end else begin
                priority casez (exec_byte)
                    8'b1???????: cur_n = {exec_byte[6], 2'b00, exec_byte[3:0]};
                    8'b001?????: begin
`ifdef LCD_DECODE_4BIT_EN
                        dl_n = ~exec_byte[4];
`endif
                    end
                    8'b00001???: disp_n = exec_byte[2];
                    8'b000001??: inc_n = exec_byte[1];
                    8'b0000001?: cur_n = 7'h00;
                    8'b00000001: begin
                        cur_n  = 7'h00;
                        inc_n  = 1'b1;
                        go_clr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Input sampling, control state and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            db_q       <= 8'h00;
            state      <= IDLE;
            clr_idx    <= 5'd0;
            cursor     <= 7'h00;
            inc        <= 1'b1;
            display_on <= 1'b0;
            proto_err  <= 1'b0;
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;
            rx_byte    <= 8'h00;
`ifdef LCD_DECODE_4BIT_EN
            dl         <= 1'b0;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
`endif
        end else begin
            e_q        <= lcd_e;
            rs_q       <= lcd_rs;
            rw_q       <= lcd_rw;
            db_q       <= lcd_db;
            cmd_valid  <= exec & ~exec_rs;
            char_valid <= exec & exec_rs;
            cursor     <= cur_n;
            inc        <= inc_n;
            display_on <= disp_n;
            if (exec) rx_byte <= exec_byte;
            if (bad | rs_err) proto_err <= 1'b1;
            if (go_clr) clr_idx <= 5'd0;
            else if (in_clear) clr_idx <= clr_idx + 5'd1;
`ifdef LCD_DECODE_4BIT_EN
            dl <= dl_n;
            if (hi_edge) begin
                hi_nib <= db_q[7:4];
                hi_rs  <= rs_q;
            end
`endif
            if (go_clr) state <= CLEAR;
            else if (in_clear && clr_idx == CLR_LAST) state <= IDLE;
`ifdef LCD_DECODE_4BIT_EN
            else if (hi_edge) state <= LOW_NIB;
            else if (lo_edge) state <= IDLE;
`endif
        end
    end

    // Character buffer: clear fill or data write, never both at once
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (in_clear) mem[clr_idx] <= 8'h20;
            else if (exec && exec_rs) mem[wr_addr] <= exec_byte;
        end
    end

    // Registered read port; same-cycle write returns the old value
    always_ff @(posedge clk) begin
        if (reset) rd_data <= 8'h00;
        else       rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: scoreboard bench for lcd_bus_decoder.
// Works with or without LCD_DECODE_4BIT_EN defined.
module tb_lcd_bus_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_db = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data, rx_byte;
    logic       cmd_valid, char_valid, four_bit, display_on, busy, proto_err;
    logic [6:0] cursor;

    lcd_bus_decoder dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_db(lcd_db), .rd_addr(rd_addr),
        .rd_data(rd_data), .cmd_valid(cmd_valid), .char_valid(char_valid),
        .rx_byte(rx_byte), .cursor(cursor), .four_bit(four_bit),
        .display_on(display_on), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb [$];

    logic [6:0] m_cur;
    logic       m_inc, m_disp, m_four;
    logic [7:0] m_mem [0:31];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected byte
    always @(negedge clk) begin
        logic [8:0] e;
        if (cmd_valid || char_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'd0, cmd_valid, char_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse", {22'd0, char_valid, cmd_valid, rx_byte},
                    {22'd0, e[8], ~e[8], e[7:0]});
            end
        end
    end

    function automatic logic [6:0] m_adv(input logic [6:0] c, input logic up);
        logic ln;
        logic [3:0] col;
        ln  = c[6];
        col = c[3:0];
        if (up) begin
            if (col == 4'd15) begin ln = ~ln; col = 4'd0; end
            else col = col + 4'd1;
        end else begin
            if (col == 4'd0) begin ln = ~ln; col = 4'd15; end
            else col = col - 4'd1;
        end
        return {ln, 2'b00, col};
    endfunction

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_db = d; lcd_e = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lcd_e = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_cur = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_four = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one byte; accepted bytes are pushed and applied to the model
    task automatic send(input logic rs, input logic rw, input logic [7:0] b,
                        input logic drop);
        logic use4;
        use4 = m_four;
        if (!drop && !rw) begin
            sb.push_back({rs, b});
            if (rs) begin
                m_mem[{m_cur[6], m_cur[3:0]}] = b;
                m_cur = m_adv(m_cur, m_inc);
            end else if (b[7]) m_cur = {b[6], 2'b00, b[3:0]};
            else if (b[7:5] == 3'b001) begin
`ifdef LCD_DECODE_4BIT_EN
                m_four = ~b[4];
`endif
            end
            else if (b[7:3] == 5'b00001) m_disp = b[2];
            else if (b[7:2] == 6'b000001) m_inc = b[1];
            else if (b[7:1] == 7'b0000001) m_cur = 7'h00;
            else if (b == 8'h01) begin
                m_cur = 7'h00; m_inc = 1'b1;
                for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            end
        end
        if (use4) begin
            pulse(rs, rw, {b[7:4], 4'h5});
            pulse(rs, rw, {b[3:0], 4'hA});
        end else begin
            pulse(rs, rw, b);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(tag, {24'd0, rd_data}, {24'd0, m_mem[a]});
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cursor", {25'd0, cursor}, 32'd0);
        chk("rst_four", {31'd0, four_bit}, 32'd0);
        chk("rst_disp", {31'd0, display_on}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        chk("rst_rx", {24'd0, rx_byte}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);
        chk("rst_pulse", {30'd0, cmd_valid, char_valid}, 32'd0);

        send(0, 0, 8'h30, 0);
        send(0, 0, 8'h30, 0);
        send(0, 0, 8'h30, 0);
        send(0, 0, 8'h20, 0);
        chk("four_after_20", {31'd0, four_bit}, {31'd0, m_four});
        send(0, 0, 8'h28, 0);
        chk("four_after_28", {31'd0, four_bit}, {31'd0, m_four});

        send(0, 0, 8'h0C, 0);
        chk("display_on", {31'd0, display_on}, {31'd0, m_disp});
        send(0, 0, 8'h01, 0);
        wait_clear(n);
        chk("busy_cycles", n, 32'd32);
        chk("clr_cursor", {25'd0, cursor}, {25'd0, m_cur});
        for (int a = 0; a < 32; a++) rd(5'(a), "clr_cell");

        send(0, 0, 8'h80, 0);
        send(1, 0, 8'h41, 0);
        send(1, 0, 8'h42, 0);
        chk("cur_02", {25'd0, cursor}, {25'd0, m_cur});
        rd(5'd0, "cell0");
        rd(5'd1, "cell1");

        send(0, 0, 8'h8F, 0);
        send(1, 0, 8'h58, 0);
        send(1, 0, 8'h59, 0);
        chk("cur_41", {25'd0, cursor}, {25'd0, m_cur});
        rd(5'd15, "cell15");
        rd(5'd16, "cell16");

        send(0, 0, 8'h04, 0);
        send(0, 0, 8'hC0, 0);
        send(1, 0, 8'h5A, 0);
        chk("cur_wrap_0f", {25'd0, cursor}, {25'd0, m_cur});
        rd(5'd16, "cell16_dec");

        chk("perr_clean", {31'd0, proto_err}, 32'd0);
        send(0, 0, 8'h01, 0);
        send(1, 0, 8'h33, 1);
        chk("perr_busy", {31'd0, proto_err}, 32'd1);
        wait_clear(n);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        rd(5'd0, "cell0_after_drop");

        do_reset();
        chk("perr_reset", {31'd0, proto_err}, 32'd0);
        send(1, 1, 8'h44, 0);
        chk("perr_rw", {31'd0, proto_err}, 32'd1);
        chk("rw_cursor", {25'd0, cursor}, {25'd0, m_cur});
        send(1, 0, 8'h45, 0);
        chk("cur_after_rw", {25'd0, cursor}, {25'd0, m_cur});

        send(0, 0, 8'h01, 0);
        repeat (3) @(negedge clk);
        chk("busy_mid_clear", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("busy_reset", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        model_reset();

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
